// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multi-cycle CPU core: opcodes, FSM state encoding and
// instruction-field helpers. Opcode 9 (MUL) is only decoded when CPU_MUL_EN is defined.
package cpu_core_pkg;

  // Opcode field is fixed at 4 bits regardless of register count.
  localparam int unsigned OpW = 4;

  typedef logic [OpW-1:0] opcode_t;

  localparam opcode_t OpAdd  = 4'd0;
  localparam opcode_t OpSub  = 4'd1;
  localparam opcode_t OpAnd  = 4'd2;
  localparam opcode_t OpOr   = 4'd3;
  localparam opcode_t OpXor  = 4'd4;
  localparam opcode_t OpSlt  = 4'd5;
  localparam opcode_t OpLi   = 4'd6;
  localparam opcode_t OpBeqz = 4'd7;
  localparam opcode_t OpJr   = 4'd8;
  localparam opcode_t OpMul  = 4'd9;
  localparam opcode_t OpHalt = 4'd15;

  // FSM state encoding, kept as plain constants for compatibility with older tools.
  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFetch  = 3'd1;
  localparam state_t StDecode = 3'd2;
  localparam state_t StExec   = 3'd3;
  localparam state_t StWb     = 3'd4;
  localparam state_t StHalted = 3'd5;

  // Instruction layout, MSB to LSB: op | rd | rs | rt.
  function automatic int unsigned instr_width(input int unsigned reg_addr_w);
    return OpW + 3 * reg_addr_w;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned reg_addr_w);
    return 2 * reg_addr_w;
  endfunction

  function automatic int unsigned rs_lsb(input int unsigned reg_addr_w);
    return reg_addr_w;
  endfunction

  // Immediate is the concatenation {rs, rt}.
  function automatic int unsigned imm_width(input int unsigned reg_addr_w);
    return 2 * reg_addr_w;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// R0 reads as zero and ignores writes; every entry clears on synchronous reset.
module cpu_regfile #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]     rdata_b_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  // Next-state: single write, writes to R0 dropped.
  always_comb begin
    regs_d = regs_q;
    if (we_i && (waddr_i != '0)) begin
      regs_d[waddr_i] = wdata_i;
    end
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports force R0 to zero independent of storage contents.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
  end

endmodule

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH over a req/valid handshake, DECODE, EXEC on an internal
// ALU, WB into the internal register file. Optional macro CPU_MUL_EN enables opcode 9
// (MUL, low DATA_W bits of the unsigned product); without it opcode 9 is illegal.
// Assumes DATA_W > 2*REG_ADDR_W so the immediate needs real sign extension.
module cpu_core_mc
  import cpu_core_pkg::*;
#(
  parameter int unsigned       DATA_W     = 10,
  parameter int unsigned       REG_ADDR_W = 3,
  parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  output logic                          imem_req,
  output logic [DATA_W-1:0]             imem_addr,
  input  logic                          imem_valid,
  input  logic [OpW+3*REG_ADDR_W-1:0]   imem_rdata,
  output logic [DATA_W-1:0]             pc_out,
  output logic [DATA_W-1:0]             alu_result,
  output logic                          retire,
  output logic                          halted,
  output logic                          illegal
);

  localparam int unsigned InstrW = instr_width(REG_ADDR_W);
  localparam int unsigned RdLsb  = rd_lsb(REG_ADDR_W);
  localparam int unsigned RsLsb  = rs_lsb(REG_ADDR_W);
  localparam int unsigned ImmW   = imm_width(REG_ADDR_W);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [InstrW-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   npc_q, npc_d;
  logic                illegal_q, illegal_d;

  // Decoded instruction fields.
  opcode_t                op;
  logic [REG_ADDR_W-1:0]  rd, rs, rt;
  logic [ImmW-1:0]        imm;
  logic [DATA_W-1:0]      imm_sext;

  assign op       = instr_q[InstrW-1 -: OpW];
  assign rd       = instr_q[RdLsb +: REG_ADDR_W];
  assign rs       = instr_q[RsLsb +: REG_ADDR_W];
  assign rt       = instr_q[REG_ADDR_W-1:0];
  assign imm      = instr_q[ImmW-1:0];
  assign imm_sext = {{(DATA_W - ImmW){imm[ImmW-1]}}, imm};

  // Register file hookup.
  logic [REG_ADDR_W-1:0] rf_raddr_a;
  logic [DATA_W-1:0]     rf_rdata_a, rf_rdata_b;
  logic                  rf_we;

  // BEQZ tests R[rd]; everything else uses rs on port A.
  assign rf_raddr_a = (op == OpBeqz) ? rd : rs;

  cpu_regfile #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .raddr_a_i (rf_raddr_a),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (rt),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (alu_q)
  );

  // Opcode classification: legality and whether the result is written to rd.
  logic op_legal, op_writes;

  always_comb begin
    op_legal  = 1'b1;
    op_writes = 1'b0;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSlt, OpLi: op_writes = 1'b1;
      OpBeqz, OpJr, OpHalt: ;
`ifdef CPU_MUL_EN
      OpMul: op_writes = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // Combinational ALU on the operands latched during DECODE.
  logic [DATA_W-1:0] alu_out;
  logic              slt_bit;

  assign slt_bit = $signed(opa_q) < $signed(opb_q);

  always_comb begin
    alu_out = '0;
    case (op)
      OpAdd: alu_out = opa_q + opb_q;
      OpSub: alu_out = opa_q - opb_q;
      OpAnd: alu_out = opa_q & opb_q;
      OpOr:  alu_out = opa_q | opb_q;
      OpXor: alu_out = opa_q ^ opb_q;
      OpSlt: alu_out = {{(DATA_W - 1){1'b0}}, slt_bit};
      OpLi:  alu_out = imm_sext;
`ifdef CPU_MUL_EN
      OpMul: alu_out = opa_q * opb_q;
`endif
      default: alu_out = '0;
    endcase
  end

  // Next-PC computation; all arithmetic wraps modulo 2**DATA_W.
  logic [DATA_W-1:0] pc_seq, npc_calc;

  assign pc_seq = pc_q + DATA_W'(1);

  always_comb begin
    npc_calc = pc_seq;
    case (op)
      OpBeqz:  npc_calc = (opa_q == '0) ? (pc_q + imm_sext) : pc_seq;
      OpJr:    npc_calc = opa_q;
      default: npc_calc = pc_seq;
    endcase
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    alu_d     = alu_q;
    npc_d     = npc_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opa_d = rf_rdata_a;
        opb_d = rf_rdata_b;
        if (!op_legal) begin
          illegal_d = 1'b1;
          state_d   = StHalted;
        end else if (op == OpHalt) begin
          state_d = StHalted;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        // Branches and jumps leave the last ALU result visible.
        if (op_writes) alu_d = alu_out;
        npc_d   = npc_calc;
        state_d = StWb;
      end
      StWb: begin
        rf_we   = op_writes;
        pc_d    = npc_q;
        state_d = run ? StFetch : StIdle;
      end
      StHalted: ;
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any in-flight instruction on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      alu_q     <= '0;
      npc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      alu_q     <= alu_d;
      npc_q     <= npc_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decoded straight from the registered state.
  always_comb begin
    imem_req   = (state_q == StFetch);
    imem_addr  = pc_q;
    pc_out     = pc_q;
    alu_result = alu_q;
    retire     = (state_q == StWb);
    halted     = (state_q == StHalted);
    illegal    = illegal_q;
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: table of short programs with hand-computed results, handwritten
// timing/stall/halt/reset sequences, and random programs against an ISA-level model.
module tb_cpu_core_mc;

  localparam int DW  = 10;
  localparam int RAW = 3;
  localparam int IW  = 4 + 3 * RAW;
  localparam int NV  = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_valid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic [DW-1:0] pc_out;
  logic [DW-1:0] alu_result;
  logic          retire;
  logic          halted;
  logic          illegal;

  cpu_core_mc #(
    .DATA_W     (DW),
    .REG_ADDR_W (RAW),
    .RESET_PC   ('0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .retire     (retire),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [IW-1:0] mem [1024];

  // Stall control: main flow arms a stall by toggling stall_arm; the responder owns the count.
  int stall_n    = 0;
  bit stall_arm  = 1'b0;
  bit rand_stall = 1'b0;

  // Instruction memory responder, driving just after each rising edge.
  initial begin
    int left;
    bit seen_arm;
    left = 0;
    seen_arm = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stall_arm != seen_arm) begin
        left = stall_n;
        seen_arm = stall_arm;
      end
      if (imem_req) begin
        if (left > 0) begin
          imem_valid = 1'b0;
          left--;
        end else if (rand_stall && ($urandom_range(2) == 0)) begin
          imem_valid = 1'b0;
        end else begin
          imem_valid = 1'b1;
        end
        imem_rdata = mem[imem_addr];
      end else begin
        imem_valid = 1'($urandom_range(1));
        imem_rdata = IW'($urandom);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 3'(rd), 3'(rs), 3'(rt)};
  endfunction

  function automatic logic [IW-1:0] enc_i(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 6'(imm)};
  endfunction

  logic [IW-1:0] hlt;

  task automatic fill_halt();
    for (int a = 0; a < 1024; a++) mem[a] = hlt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, int'(pc_out), 0);
    check({tag, "_req"}, int'(imem_req), 0);
    check({tag, "_alu"}, int'(alu_result), 0);
    check({tag, "_retire"}, int'(retire), 0);
    check({tag, "_halted"}, int'(halted), 0);
    check({tag, "_illegal"}, int'(illegal), 0);
  endtask

  // Table of programs placed at address 0, rest of memory filled with HALT.
  typedef struct packed {
    logic [5:0][IW-1:0] prog;
    logic [DW-1:0]      alu;
    logic [DW-1:0]      pc;
    logic               ill;
  } vec_t;

  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic [IW-1:0] p0, input logic [IW-1:0] p1,
                         input logic [IW-1:0] p2, input logic [IW-1:0] p3,
                         input logic [IW-1:0] p4, input logic [IW-1:0] p5,
                         input int alu, input int pc, input bit ill);
    vecs[i].prog[0] = p0;
    vecs[i].prog[1] = p1;
    vecs[i].prog[2] = p2;
    vecs[i].prog[3] = p3;
    vecs[i].prog[4] = p4;
    vecs[i].prog[5] = p5;
    vecs[i].alu = DW'(alu);
    vecs[i].pc  = DW'(pc);
    vecs[i].ill = ill;
  endtask

  // ISA-level reference model.
  int m_reg [8];
  int m_pc;
  int m_alu;

  // kind: 0 = retires normally, 1 = HALT, 2 = illegal.
  task automatic model_step(output int kind);
    int ins, op, rd, rs, rt, imm, a, b, sa, sb, res, nxt;
    bit wr;
    ins = int'(mem[m_pc]);
    op  = ins >> 9;
    rd  = (ins >> 6) & 7;
    rs  = (ins >> 3) & 7;
    rt  = ins & 7;
    imm = ins & 63;
    if (imm >= 32) imm -= 64;
    a   = m_reg[rs];
    b   = m_reg[rt];
    kind = 0;
    wr   = 1'b0;
    res  = 0;
    nxt  = m_pc + 1;
    case (op)
      0: begin res = a + b; wr = 1'b1; end
      1: begin res = a - b; wr = 1'b1; end
      2: begin res = a & b; wr = 1'b1; end
      3: begin res = a | b; wr = 1'b1; end
      4: begin res = a ^ b; wr = 1'b1; end
      5: begin
        sa = (a >= 512) ? a - 1024 : a;
        sb = (b >= 512) ? b - 1024 : b;
        res = (sa < sb) ? 1 : 0;
        wr = 1'b1;
      end
      6: begin res = imm; wr = 1'b1; end
      7: nxt = (m_reg[rd] == 0) ? m_pc + imm : m_pc + 1;
      8: nxt = a;
`ifdef CPU_MUL_EN
      9: begin res = a * b; wr = 1'b1; end
`endif
      15: kind = 1;
      default: kind = 2;
    endcase
    if (kind == 0) begin
      if (wr) begin
        m_alu = res & 1023;
        if (rd != 0) m_reg[rd] = res & 1023;
      end
      m_pc = nxt & 1023;
    end
  endtask

  function automatic logic [IW-1:0] rand_instr();
    int r;
    r = int'($urandom_range(127));
    if (r == 0) return hlt;
    if (r == 1) return {4'($urandom_range(14, 9)), 9'($urandom)};
    return {4'($urandom_range(8)), 9'($urandom)};
  endfunction

  initial begin
    bit ok;
    int kind;
    int t [3];
    int nret, req_cnt, bad;

    hlt = enc_r(15, 0, 0, 0);

    set_vec(0, enc_i(6, 1, 5), enc_i(6, 2, 3), enc_r(0, 3, 1, 2), hlt, hlt, hlt, 8, 3, 0);
    set_vec(1, enc_i(6, 1, 1), enc_r(1, 2, 0, 1), hlt, hlt, hlt, hlt, 'h3FF, 2, 0);
    set_vec(2, enc_i(6, 1, -1), enc_i(6, 2, 21), enc_r(2, 3, 1, 2), hlt, hlt, hlt, 21, 3, 0);
    set_vec(3, enc_i(6, 1, 12), enc_i(6, 2, 10), enc_r(4, 3, 1, 2), hlt, hlt, hlt, 6, 3, 0);
    set_vec(4, enc_i(6, 1, 12), enc_i(6, 2, 10), enc_r(3, 3, 1, 2), hlt, hlt, hlt, 14, 3, 0);
    set_vec(5, enc_i(6, 1, -3), enc_i(6, 2, 2), enc_r(5, 3, 1, 2), hlt, hlt, hlt, 1, 3, 0);
    set_vec(6, enc_i(6, 1, 2), enc_i(6, 2, -3), enc_r(5, 3, 1, 2), hlt, hlt, hlt, 0, 3, 0);
    set_vec(7, enc_i(6, 1, 31), enc_i(6, 2, -32), hlt, hlt, hlt, hlt, 'h3E0, 2, 0);
`ifdef CPU_MUL_EN
    set_vec(8, enc_i(6, 1, 31), enc_i(6, 2, 31), enc_i(6, 3, 2), enc_r(0, 2, 2, 3),
            enc_r(9, 4, 1, 2), hlt, 1023, 5, 0);
`else
    set_vec(8, enc_i(6, 1, 31), enc_i(6, 2, 31), enc_i(6, 3, 2), enc_r(0, 2, 2, 3),
            enc_r(9, 4, 1, 2), hlt, 33, 4, 1);
`endif
    set_vec(9, enc_i(6, 1, 5), enc_r(8, 0, 1, 0), hlt, hlt, hlt, hlt, 5, 5, 0);
    set_vec(10, enc_i(6, 0, 7), enc_r(0, 1, 0, 0), hlt, hlt, hlt, hlt, 0, 2, 0);
    set_vec(11, enc_i(7, 0, 3), hlt, hlt, enc_i(6, 3, 9), enc_i(7, 0, -2), hlt, 9, 2, 0);
    set_vec(12, enc_i(6, 1, 1), enc_i(7, 1, -2), hlt, hlt, hlt, hlt, 1, 2, 0);
    set_vec(13, enc_r(10, 1, 2, 3), hlt, hlt, hlt, hlt, hlt, 0, 0, 1);

    // Reset state, then LI/LI/ADD with a 5-cycle fetch stall before the ADD.
    fill_halt();
    mem[0] = enc_i(6, 1, 5);
    mem[1] = enc_i(6, 2, 3);
    mem[2] = enc_r(0, 3, 1, 2);
    do_reset();
    check_reset_state("rst");
    run = 1'b1;
    nret = 0;
    req_cnt = 0;
    bad = 0;
    for (int c = 0; c < 200 && !halted; c++) begin
      @(negedge clk);
      if (nret == 2 && imem_req) begin
        req_cnt++;
        if (imem_addr != 10'd2) bad++;
      end
      if (retire) begin
        if (nret < 3) t[nret] = cyc;
        nret++;
        if (nret == 2) begin
          stall_n = 5;
          stall_arm = ~stall_arm;
        end
      end
    end
    check("seq_retires", nret, 3);
    if (nret == 3) begin
      check("seq_retire_gap", t[1] - t[0], 4);
      check("seq_stall_gap", t[2] - t[1], 9);
    end
    check("seq_stall_req_cycles", req_cnt, 6);
    check("seq_stall_addr_moved", bad, 0);
    check("seq_alu", int'(alu_result), 8);
    check("seq_pc", int'(pc_out), 3);

    // Table-driven programs.
    for (int i = 0; i < NV; i++) begin
      fill_halt();
      for (int k = 0; k < 6; k++) mem[k] = vecs[i].prog[k];
      do_reset();
      run = 1'b1;
      wait_halt(300, ok);
      check($sformatf("vec%0d_halt", i), int'(ok), 1);
      check($sformatf("vec%0d_alu", i), int'(alu_result), int'(vecs[i].alu));
      check($sformatf("vec%0d_pc", i), int'(pc_out), int'(vecs[i].pc));
      check($sformatf("vec%0d_illegal", i), int'(illegal), int'(vecs[i].ill));
    end

    // Reset clears the sticky illegal/halted flags left by the last vector.
    do_reset();
    check_reset_state("rst_after_ill");

    // HALT at pc 4 is sticky; run is ignored; reset recovers.
    fill_halt();
    for (int k = 0; k < 4; k++) mem[k] = enc_i(6, k + 1, k + 1);
    do_reset();
    run = 1'b1;
    wait_halt(200, ok);
    check("halt_seen", int'(ok), 1);
    check("halt_pc", int'(pc_out), 4);
    check("halt_alu", int'(alu_result), 4);
    check("halt_illegal", int'(illegal), 0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      run = 1'($urandom_range(1));
      @(negedge clk);
      if (imem_req || !halted || retire || pc_out != 10'd4) bad++;
    end
    check("halt_sticky", bad, 0);
    do_reset();
    check_reset_state("rst_after_halt");

    // Reset during EXEC of the ADD: no retire, back to idle.
    fill_halt();
    mem[0] = enc_i(6, 1, 5);
    mem[1] = enc_i(6, 2, 3);
    mem[2] = enc_r(0, 3, 1, 2);
    do_reset();
    run = 1'b1;
    nret = 0;
    for (int c = 0; c < 100 && nret < 2; c++) begin
      @(negedge clk);
      if (retire) nret++;
    end
    check("mid_exec_two_retires", nret, 2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    check("mid_exec_no_retire", int'(retire), 0);
    check("mid_exec_req", int'(imem_req), 0);
    check("mid_exec_alu", int'(alu_result), 0);
    check("mid_exec_pc", int'(pc_out), 0);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (retire || imem_req) bad++;
    end
    check("mid_exec_idle", bad, 0);
    run = 1'b1;
    @(negedge clk);
    check("idle_to_fetch", int'(imem_req), 1);

    // Random programs against the ISA model, with random fetch stalls.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 1024; a++) mem[a] = rand_instr();
      do_reset();
      for (int k = 0; k < 8; k++) m_reg[k] = 0;
      m_pc = 0;
      m_alu = 0;
      rand_stall = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 800; c++) begin
        @(negedge clk);
        if (retire) begin
          check("rnd_pc", int'(pc_out), m_pc);
          model_step(kind);
          check("rnd_kind", kind, 0);
          check("rnd_alu", int'(alu_result), m_alu);
        end
        if (halted) begin
          check("rnd_halt_pc", int'(pc_out), m_pc);
          model_step(kind);
          check("rnd_halt_expected", (kind != 0) ? 1 : 0, 1);
          check("rnd_illegal", int'(illegal), (kind == 2) ? 1 : 0);
          break;
        end
      end
      rand_stall = 1'b0;
      run = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
